array_rf_burst_ctrl: RTL and testbench

Parametrised successor to the single-row array refresh controller.
- Each rf_start runs a burst of 0..2^BURST_CNT_WIDTH-1 row refreshes.
- Covers BANK_NUM banks, either all-bank (simultaneous) or per-bank (sequential).
- Keeps a wrapping row pointer across bursts.
- Sits between fsm_ctrl (start/done handshake) and array_if_sel (bank select and row address); timing comes from mc_apb_cfg registers.

---
 rtl/array_ctrl_pkg.sv | 25 ++
 rtl/array_rf_timer.sv | 31 +++
 rtl/array_rf_burst_ctrl.sv | 179 +++++++++++++++++
 tb/tb_array_rf_burst_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the array refresh controllers.
//   rf_state_e        : refresh FSM states (IDLE/RAS/RP/DONE)
//   RF_MODE_ALL       : all banks refreshed together
//   RF_MODE_PER_BANK  : banks refreshed one after another
//   TIMING_CNT_WIDTH  : width of the tRAS/tRP configuration and timers
//   clamp_min1()      : maps a zero timing value to one cycle
package array_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAS  = 2'd1,
      ST_RP   = 2'd2,
      ST_DONE = 2'd3
   } rf_state_e;

   localparam logic RF_MODE_ALL      = 1'b0;
   localparam logic RF_MODE_PER_BANK = 1'b1;
   localparam int   TIMING_CNT_WIDTH = 8;

   function automatic logic [TIMING_CNT_WIDTH-1:0] clamp_min1(
      input logic [TIMING_CNT_WIDTH-1:0] v);
      return (v == '0) ? TIMING_CNT_WIDTH'(1) : v;
   endfunction

endpackage

// File: rtl/array_rf_timer.sv
// Loadable down-counter timing one RAS or RP phase.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_load       : load i_load_val (zero is loaded as one)
//   i_load_val   : phase length in cycles
//   o_expire     : high during the last cycle of the loaded phase
module array_rf_timer
   import array_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_load,
   input  logic [TIMING_CNT_WIDTH-1:0] i_load_val,
   output logic                        o_expire
);

   logic [TIMING_CNT_WIDTH-1:0] r_cnt;

   // The load happens on the edge entering the phase, so the count equals
   // the remaining cycles of the phase including the current one.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= clamp_min1(i_load_val);
      else if (r_cnt != '0)
         r_cnt <= r_cnt - TIMING_CNT_WIDTH'(1);
   end

   assign o_expire = (r_cnt == TIMING_CNT_WIDTH'(1));

endmodule

// File: rtl/array_rf_burst_ctrl.sv
// Burst refresh controller: each rf_start refreshes mc_rf_burst_cfg rows,
// either in all banks at once or bank by bank, with a wrapping row pointer.
//   clk, rst_n          : clock, synchronous active-low reset
//   mc_tras_cfg         : RAS cycles per refresh (0 acts as 1)
//   mc_trp_cfg          : RP cycles per refresh (0 acts as 1)
//   mc_rf_burst_cfg     : rows per rf_start
//   mc_rf_mode_cfg      : 0 all-bank, 1 per-bank sequential
//   rf_start            : start request (ignored while busy)
//   rf_abort            : stop after the current row/bank (ARRAY_RF_ABORT_EN only)
//   rf_done             : one-cycle completion pulse
//   rf_busy             : high outside IDLE
//   array_banksel_n_rf  : active-low bank selects
//   array_raddr_rf      : row being refreshed
// Optional feature macro: ARRAY_RF_ABORT_EN
module array_rf_burst_ctrl
   import array_ctrl_pkg::*;
#(
   parameter int AXI_RADDR_WIDTH = 14,
   parameter int BANK_NUM        = 4,
   parameter int BURST_CNT_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [TIMING_CNT_WIDTH-1:0] mc_tras_cfg,
   input  logic [TIMING_CNT_WIDTH-1:0] mc_trp_cfg,
   input  logic [BURST_CNT_WIDTH-1:0]  mc_rf_burst_cfg,
   input  logic                        mc_rf_mode_cfg,
   input  logic                        rf_start,
`ifdef ARRAY_RF_ABORT_EN
   input  logic                        rf_abort,
`endif
   output logic                        rf_done,
   output logic                        rf_busy,
   output logic [BANK_NUM-1:0]         array_banksel_n_rf,
   output logic [AXI_RADDR_WIDTH-1:0]  array_raddr_rf
);

   localparam int BANK_IDX_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
   localparam logic [BANK_IDX_W-1:0] LAST_BANK = BANK_IDX_W'(BANK_NUM - 1);

   rf_state_e                   r_state, w_state_nxt;
   logic [AXI_RADDR_WIDTH-1:0]  r_row, w_row_nxt;
   logic [BANK_IDX_W-1:0]       r_bank, w_bank_nxt;
   logic [BURST_CNT_WIDTH-1:0]  r_burst, w_burst_nxt;
   logic [TIMING_CNT_WIDTH-1:0] r_tras, r_trp;
   logic                        r_mode;
   logic                        w_latch;
   logic                        w_tmr_load;
   logic [TIMING_CNT_WIDTH-1:0] w_tmr_val;
   logic                        w_tmr_exp;
   logic                        w_row_done;
   logic                        w_abort;
   logic [BANK_NUM-1:0]         w_banksel_n;

   array_rf_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_expire   (w_tmr_exp)
   );

`ifdef ARRAY_RF_ABORT_EN
   logic r_abort;

   // Sticky while a burst runs; an abort seen in the final RP cycle counts too.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_abort <= 1'b0;
      else if (r_state == ST_IDLE || r_state == ST_DONE)
         r_abort <= 1'b0;
      else if (rf_abort)
         r_abort <= 1'b1;
   end

   assign w_abort = r_abort | (rf_abort & (r_state == ST_RP));
`else
   assign w_abort = 1'b0;
`endif

   // A row is finished once its last bank has been precharged.
   assign w_row_done = (r_mode == RF_MODE_ALL) || (r_bank == LAST_BANK);

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_bank_nxt  = r_bank;
      w_burst_nxt = r_burst;
      w_latch     = 1'b0;
      w_tmr_load  = 1'b0;
      w_tmr_val   = r_tras;
      case (r_state)
         ST_IDLE: begin
            if (rf_start) begin
               w_latch     = 1'b1;
               w_bank_nxt  = '0;
               w_burst_nxt = mc_rf_burst_cfg;
               if (mc_rf_burst_cfg == '0) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  // Config registers are not written yet; use the live input.
                  w_state_nxt = ST_RAS;
                  w_tmr_load  = 1'b1;
                  w_tmr_val   = mc_tras_cfg;
               end
            end
         end
         ST_RAS: begin
            if (w_tmr_exp) begin
               w_state_nxt = ST_RP;
               w_tmr_load  = 1'b1;
               w_tmr_val   = r_trp;
            end
         end
         ST_RP: begin
            if (w_tmr_exp) begin
               if (!w_row_done && !w_abort) begin
                  w_bank_nxt  = r_bank + BANK_IDX_W'(1);
                  w_state_nxt = ST_RAS;
                  w_tmr_load  = 1'b1;
               end else begin
                  w_bank_nxt = '0;
                  // A partially refreshed row is retried by the next burst.
                  if (w_row_done) begin
                     w_row_nxt   = r_row + AXI_RADDR_WIDTH'(1);
                     w_burst_nxt = r_burst - BURST_CNT_WIDTH'(1);
                  end
                  if (w_abort || (r_burst == BURST_CNT_WIDTH'(1))) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_state_nxt = ST_RAS;
                     w_tmr_load  = 1'b1;
                  end
               end
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_bank  <= '0;
         r_burst <= '0;
         r_tras  <= '0;
         r_trp   <= '0;
         r_mode  <= RF_MODE_ALL;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_bank  <= w_bank_nxt;
         r_burst <= w_burst_nxt;
         if (w_latch) begin
            r_tras <= mc_tras_cfg;
            r_trp  <= mc_trp_cfg;
            r_mode <= mc_rf_mode_cfg;
         end
      end
   end

   always_comb begin
      w_banksel_n = '1;
      if (r_state == ST_RAS) begin
         for (int i = 0; i < BANK_NUM; i++) begin
            if (r_mode == RF_MODE_ALL || r_bank == BANK_IDX_W'(i))
               w_banksel_n[i] = 1'b0;
         end
      end
   end

   assign array_banksel_n_rf = w_banksel_n;
   assign array_raddr_rf     = r_row;
   assign rf_done            = (r_state == ST_DONE);
   assign rf_busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_array_rf_burst_ctrl.sv
// Self-checking bench for array_rf_burst_ctrl (3-bit row address build so
// the row pointer wraps quickly). Expected traces come from a per-burst
// schedule model: a list of (row, bank) refresh units, each tRAS select
// cycles followed by tRP idle cycles, then one done cycle.
module tb_array_rf_burst_ctrl;

   localparam int AW = 3;
   localparam int BN = 4;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    tras = '0, trp = '0;
   logic [BW-1:0] burst = '0;
   logic          mode = 1'b0;
   logic          rf_start = 1'b0;
   logic          rf_abort = 1'b0;
   logic          rf_done, rf_busy;
   logic [BN-1:0] sel_n;
   logic [AW-1:0] raddr;

   int checks = 0;
   int failures = 0;
   int model_row = 0;

   logic [BN-1:0] q_sel[$];
   logic [AW-1:0] q_addr[$];
   bit            q_done[$];

   always #5 clk = ~clk;

   array_rf_burst_ctrl #(
      .AXI_RADDR_WIDTH (AW),
      .BANK_NUM        (BN),
      .BURST_CNT_WIDTH (BW)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .mc_tras_cfg        (tras),
      .mc_trp_cfg         (trp),
      .mc_rf_burst_cfg    (burst),
      .mc_rf_mode_cfg     (mode),
      .rf_start           (rf_start),
`ifdef ARRAY_RF_ABORT_EN
      .rf_abort           (rf_abort),
`endif
      .rf_done            (rf_done),
      .rf_busy            (rf_busy),
      .array_banksel_n_rf (sel_n),
      .array_raddr_rf     (raddr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Builds the expected cycle-by-cycle trace starting with the cycle after
   // rf_start is sampled. abort_cyc >= 0 truncates after the unit it hits.
   task automatic build(input int ta_cfg, input int tp_cfg, input int nburst,
                        input bit pm, input int abort_cyc);
      int ta, tp, nb, units, row;
      logic [BN-1:0] s;
      ta = (ta_cfg == 0) ? 1 : ta_cfg;
      tp = (tp_cfg == 0) ? 1 : tp_cfg;
      nb = pm ? BN : 1;
      units = nburst * nb;
      if (abort_cyc >= 0 && abort_cyc < units * (ta + tp))
         units = abort_cyc / (ta + tp) + 1;
      q_sel.delete(); q_addr.delete(); q_done.delete();
      for (int u = 0; u < units; u++) begin
         row = (model_row + u / nb) % (1 << AW);
         s = pm ? ~(BN'(1) << (u % nb)) : '0;
         repeat (ta) begin q_sel.push_back(s);  q_addr.push_back(AW'(row)); q_done.push_back(1'b0); end
         repeat (tp) begin q_sel.push_back('1); q_addr.push_back(AW'(row)); q_done.push_back(1'b0); end
      end
      q_sel.push_back('1); q_addr.push_back('0); q_done.push_back(1'b1);
      model_row = (model_row + units / nb) % (1 << AW);
   endtask

   task automatic run(input int ta, input int tp, input int nburst, input bit pm,
                      input int abort_cyc, input int start_cyc, input int rst_cyc);
      bit did_rst;
      did_rst = 1'b0;
`ifndef ARRAY_RF_ABORT_EN
      abort_cyc = -1;
`endif
      build(ta, tp, nburst, pm, abort_cyc);
      @(negedge clk);
      tras = 8'(ta); trp = 8'(tp); burst = BW'(nburst); mode = pm; rf_start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < q_sel.size(); i++) begin
         @(negedge clk);
         rf_start = 1'b0; rf_abort = 1'b0;
         // Scramble live config: the burst must run on latched values.
         tras = 8'($urandom); trp = 8'($urandom);
         burst = BW'($urandom); mode = 1'($urandom);
         chk("sel_n", 32'(sel_n), 32'(q_sel[i]));
         chk("done", 32'(rf_done), 32'(q_done[i]));
         chk("busy", 32'(rf_busy), 32'd1);
         if (!q_done[i]) chk("raddr", 32'(raddr), 32'(q_addr[i]));
         if (i == abort_cyc) rf_abort = 1'b1;
         if (i == start_cyc) rf_start = 1'b1;
         if (i == rst_cyc) begin rst_n = 1'b0; did_rst = 1'b1; break; end
      end
      @(negedge clk);
      rf_start = 1'b0; rf_abort = 1'b0;
      chk("idle_busy", 32'(rf_busy), 32'd0);
      chk("idle_done", 32'(rf_done), 32'd0);
      chk("idle_sel_n", 32'(sel_n), 32'(BN'('1)));
      if (did_rst) begin
         chk("rst_raddr", 32'(raddr), 32'd0);
         rst_n = 1'b1;
         model_row = 0;
      end
   endtask

   initial begin
      int a, ab, st;
      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_sel_n", 32'(sel_n), 32'(BN'('1)));
      chk("reset_raddr", 32'(raddr), 32'd0);
      chk("reset_busy", 32'(rf_busy), 32'd0);
      chk("reset_done", 32'(rf_done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(16, 6, 1, 1'b0, -1, -1, -1);   // all-bank, done at T23
      run(1, 1, 1, 1'b0, -1, -1, -1);    // next burst on row 1
      run(4, 2, 2, 1'b1, -1, -1, -1);    // per-bank, done at T49
      run(0, 0, 0, 1'b0, -1, -1, -1);    // burst=0: immediate done
      run(0, 0, 3, 1'b1, -1, -1, -1);    // zero timings act as one cycle
      run(3, 2, 2, 1'b0, -1, 1, -1);     // start during RAS ignored
      run(4, 3, 2, 1'b0, -1, -1, 5);     // reset in RP of first row
      run(3, 2, 8, 1'b0, 11, -1, -1);    // abort in RAS of row 2
      run(2, 1, 2, 1'b1, 4, -1, -1);     // abort mid-row: pointer holds
      run(0, 0, 15, 1'b0, -1, -1, -1);   // row pointer wraps twice

      for (int k = 0; k < 30; k++) begin
         a  = $urandom_range(0, 5);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
         st = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
         run(a, $urandom_range(0, 4), $urandom_range(0, 6), 1'($urandom), ab, st, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
